// File: rtl/prefetch_unit.sv
// Instruction prefetch queue: issues sequential reads and buffers {addr, data} for a consumer.
// Latency: issue to instr_valid_o is 2 cycles; restart to valid head is 3 cycles.
// Backpressure: reads are issued only while queued plus in-flight entries leave a free slot.
module prefetch_unit #(
  parameter int                  I_WIDTH    = 12,
  parameter int                  A_WIDTH    = 8,
  parameter int                  DEPTH      = 4,
  parameter logic [A_WIDTH-1:0]  RESET_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           reset_i,
  input  logic                           restart_i,
  input  logic [A_WIDTH-1:0]             restart_addr_i,
  input  logic                           deque_i,
  output logic [A_WIDTH-1:0]             imem_addr_o,
  output logic                           imem_req_o,
  input  logic [I_WIDTH-1:0]             imem_data_i,
  output logic [I_WIDTH-1:0]             instr_data_o,
  output logic [A_WIDTH-1:0]             instr_addr_o,
  output logic                           instr_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [A_WIDTH-1:0] pc_q;
  logic [A_WIDTH-1:0] infl_addr_q;
  logic               infl_q;
  logic [CW-1:0]      count_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [PW-1:0]      wr_ptr_q;
  logic [A_WIDTH-1:0] addr_mem [DEPTH];
  logic [I_WIDTH-1:0] data_mem [DEPTH];

  logic [CW:0] occupancy;
  logic        issue;
  logic        enq;
  logic        deq;

  // A slot is reserved for every outstanding read, so the response always fits.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
  assign issue     = !reset_i && !restart_i && (occupancy < DEPTH_C);
  assign enq       = infl_q && !restart_i && !reset_i;
  assign deq       = deque_i && (count_q != '0);

  assign imem_addr_o   = pc_q;
  assign imem_req_o    = issue;
  assign instr_valid_o = !reset_i && (count_q != '0);
  assign count_o       = reset_i ? '0 : count_q;
  assign instr_addr_o  = addr_mem[rd_ptr_q];
  assign instr_data_o  = data_mem[rd_ptr_q];

  // Control state: PC, in-flight tracking, pointers and occupancy; reset beats restart beats normal flow.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      pc_q        <= RESET_ADDR;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else if (restart_i) begin
      pc_q     <= restart_addr_i;
      infl_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      infl_q <= issue;
      if (issue) begin
        pc_q        <= pc_q + A_WIDTH'(1);
        infl_addr_q <= pc_q;
      end
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (enq && !deq)      count_q <= count_q + CW'(1);
      else if (!enq && deq) count_q <= count_q - CW'(1);
    end
  end

  // Queue storage: the response arriving this cycle lands at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= infl_addr_q;
      data_mem[wr_ptr_q] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Testbench for prefetch_unit: directed table, wrap sequence, randomized run against a queue model.
// Two instances share stimulus; the second uses RESET_ADDR=8'hFE for the PC wrap case.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_prefetch_unit;

  localparam int IW = 12;
  localparam int AW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          restart_i = 1'b0;
  logic [AW-1:0] restart_addr_i = '0;
  logic          deque_i = 1'b0;

  logic [AW-1:0] imem_addr_a, imem_addr_b;
  logic          imem_req_a, imem_req_b;
  logic [IW-1:0] imem_data_a, imem_data_b;
  logic [IW-1:0] instr_data_a, instr_data_b;
  logic [AW-1:0] instr_addr_a, instr_addr_b;
  logic          instr_valid_a, instr_valid_b;
  logic [2:0]    count_a, count_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return {~a[3:0], a};
  endfunction

  // Instruction memories: data for the address requested last cycle.
  always_ff @(posedge clk) begin
    imem_data_a <= rom(imem_addr_a);
    imem_data_b <= rom(imem_addr_b);
  end

  prefetch_unit #(.I_WIDTH(IW), .A_WIDTH(AW), .DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset_i(reset_i), .restart_i(restart_i), .restart_addr_i(restart_addr_i),
    .deque_i(deque_i), .imem_addr_o(imem_addr_a), .imem_req_o(imem_req_a),
    .imem_data_i(imem_data_a), .instr_data_o(instr_data_a), .instr_addr_o(instr_addr_a),
    .instr_valid_o(instr_valid_a), .count_o(count_a));

  prefetch_unit #(.I_WIDTH(IW), .A_WIDTH(AW), .DEPTH(DEPTH), .RESET_ADDR(8'hFE)) dut_wrap (
    .clk(clk), .reset_i(reset_i), .restart_i(restart_i), .restart_addr_i(restart_addr_i),
    .deque_i(deque_i), .imem_addr_o(imem_addr_b), .imem_req_o(imem_req_b),
    .imem_data_i(imem_data_b), .instr_data_o(instr_data_b), .instr_addr_o(instr_addr_b),
    .instr_valid_o(instr_valid_b), .count_o(count_b));

  // Reference model of the first instance: a plain queue plus one outstanding read.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc = '0;
  bit            m_infl = 1'b0;
  logic [AW-1:0] m_infl_addr = '0;

  function automatic bit m_req();
    return !reset_i && !restart_i && ((mq.size() + int'(m_infl)) < DEPTH);
  endfunction

  task automatic model_edge();
    bit iss;
    iss = m_req();
    if (reset_i) begin
      mq.delete(); m_pc = 8'h00; m_infl = 1'b0;
    end else if (restart_i) begin
      mq.delete(); m_pc = restart_addr_i; m_infl = 1'b0;
    end else begin
      if (deque_i && mq.size() > 0) void'(mq.pop_front());
      if (m_infl) mq.push_back('{a: m_infl_addr, d: rom(m_infl_addr)});
      m_infl = iss;
      if (iss) begin
        m_infl_addr = m_pc;
        m_pc = m_pc + 8'd1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    else
      passed++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, 32'(instr_valid_a), 32'(!reset_i && mq.size() > 0));
    chk({tag, ".count"}, 32'(count_a), reset_i ? 32'd0 : 32'(mq.size()));
    chk({tag, ".req"}, 32'(imem_req_a), 32'(m_req()));
    chk({tag, ".pc"}, 32'(imem_addr_a), 32'(m_pc));
    if (!reset_i && mq.size() > 0) begin
      chk({tag, ".head_addr"}, 32'(instr_addr_a), 32'(mq[0].a));
      chk({tag, ".head_data"}, 32'(instr_data_a), 32'(mq[0].d));
    end
  endtask

  typedef struct {
    logic          rst;
    logic          rs;
    logic [AW-1:0] ra;
    logic          dq;
    logic          v;
    logic [AW-1:0] ha;
    logic [2:0]    c;
    logic          rq;
    logic [AW-1:0] pc;
    logic          cpc;
  } vec_t;

  vec_t tbl[20];

  initial begin
    //          rst rs ra     dq  v  ha     c  rq pc     cpc
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0};
    tbl[1]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 1};
    tbl[2]  = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h01, 1};
    tbl[3]  = '{0, 0, 8'h00, 0, 1, 8'h00, 1, 1, 8'h02, 1};
    tbl[4]  = '{0, 0, 8'h00, 0, 1, 8'h00, 2, 1, 8'h03, 1};
    tbl[5]  = '{0, 0, 8'h00, 0, 1, 8'h00, 3, 0, 8'h04, 1};
    tbl[6]  = '{0, 0, 8'h00, 0, 1, 8'h00, 4, 0, 8'h04, 1};
    tbl[7]  = '{0, 0, 8'h00, 1, 1, 8'h00, 4, 0, 8'h04, 1};
    tbl[8]  = '{0, 0, 8'h00, 0, 1, 8'h01, 3, 1, 8'h04, 1};
    tbl[9]  = '{0, 1, 8'h40, 1, 1, 8'h01, 3, 0, 8'h05, 1};
    tbl[10] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h40, 1};
    tbl[11] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 8'h41, 1};
    tbl[12] = '{0, 0, 8'h00, 0, 1, 8'h40, 1, 1, 8'h42, 1};
    tbl[13] = '{0, 0, 8'h00, 1, 1, 8'h40, 2, 1, 8'h43, 1};
    tbl[14] = '{0, 0, 8'h00, 0, 1, 8'h41, 2, 1, 8'h44, 1};
    tbl[15] = '{0, 0, 8'h00, 0, 1, 8'h41, 3, 0, 8'h45, 1};
    tbl[16] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h45, 1};
    tbl[17] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 1};
    tbl[18] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h01, 1};
    tbl[19] = '{0, 0, 8'h00, 0, 1, 8'h00, 1, 1, 8'h02, 1};

    #1;
    // Directed table: fill to full, dequeue, empty dequeue, restart with stale response, reset while full.
    for (int i = 0; i < 20; i++) begin
      reset_i = tbl[i].rst; restart_i = tbl[i].rs;
      restart_addr_i = tbl[i].ra; deque_i = tbl[i].dq;
      @(negedge clk);
      chk($sformatf("tbl%0d.valid", i), 32'(instr_valid_a), 32'(tbl[i].v));
      chk($sformatf("tbl%0d.count", i), 32'(count_a), 32'(tbl[i].c));
      chk($sformatf("tbl%0d.req", i), 32'(imem_req_a), 32'(tbl[i].rq));
      if (tbl[i].cpc) chk($sformatf("tbl%0d.pc", i), 32'(imem_addr_a), 32'(tbl[i].pc));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d.head_addr", i), 32'(instr_addr_a), 32'(tbl[i].ha));
        chk($sformatf("tbl%0d.head_data", i), 32'(instr_data_a), 32'(rom(tbl[i].ha)));
      end
      step();
    end

    // Continuous dequeue from reset: 2-cycle fill then one instruction per cycle; PC wrap on the FE instance.
    reset_i = 1'b1; restart_i = 1'b0; deque_i = 1'b1;
    step();
    reset_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stream%0d.count_le2", k), 32'(count_a <= 3'd2), 32'd1);
      if (k >= 2) begin
        chk($sformatf("stream%0d.valid", k), 32'(instr_valid_a), 32'd1);
        chk($sformatf("stream%0d.addr", k), 32'(instr_addr_a), 32'(k - 2));
      end
      if (k >= 2 && k <= 5) begin
        logic [AW-1:0] ew;
        ew = 8'hFE + 8'(k - 2);
        chk($sformatf("wrap%0d.valid", k), 32'(instr_valid_b), 32'd1);
        chk($sformatf("wrap%0d.addr", k), 32'(instr_addr_b), 32'(ew));
      end
      step();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset_i = ($urandom_range(0, 63) == 0);
      restart_i = ($urandom_range(0, 15) == 0);
      restart_addr_i = 8'($urandom_range(0, 255));
      deque_i = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      chk_model($sformatf("rnd%0d", n));
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
